// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths and types for the FFT output serializer
// Parameters: INT_WIDTH/FRACT_WIDTH word format, NFFT frame size, LATENCY FFT
// pipeline depth, DROP_CNT_WIDTH dropped-frame counter width.
package fft_pkg;

  localparam int INT_WIDTH      = 16;
  localparam int FRACT_WIDTH    = 16;
  localparam int DATA_WIDTH     = INT_WIDTH + FRACT_WIDTH;
  localparam int NFFT           = 8;
  localparam int LOG2_NFFT      = 3;
  localparam int LATENCY        = 4;
  localparam int DROP_CNT_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0]     word_t;
  typedef logic [LOG2_NFFT-1:0]      bin_t;
  typedef logic [DROP_CNT_WIDTH-1:0] drop_cnt_t;

endpackage

// File: rtl/fft_out_serializer_if.sv
// rtl/fft_out_serializer_if.sv - FFT frame input and sample stream bundle
// Inputs: fft_en, in0..in7 real/imag (parallel FFT frame), out_ready.
// Outputs: out_valid, out_real, out_imag, out_index, out_last, frame_drop,
// drop_count. master = serializer side, slave = FFT/sink side.
interface fft_out_serializer_if;
  import fft_pkg::*;

  logic      fft_en;
  word_t     in0_real, in1_real, in2_real, in3_real;
  word_t     in4_real, in5_real, in6_real, in7_real;
  word_t     in0_imag, in1_imag, in2_imag, in3_imag;
  word_t     in4_imag, in5_imag, in6_imag, in7_imag;

  logic      out_valid;
  logic      out_ready;
  word_t     out_real;
  word_t     out_imag;
  bin_t      out_index;
  logic      out_last;
  logic      frame_drop;
  drop_cnt_t drop_count;

  modport master (
    input  fft_en,
    input  in0_real, in1_real, in2_real, in3_real,
    input  in4_real, in5_real, in6_real, in7_real,
    input  in0_imag, in1_imag, in2_imag, in3_imag,
    input  in4_imag, in5_imag, in6_imag, in7_imag,
    input  out_ready,
    output out_valid, out_real, out_imag, out_index, out_last,
    output frame_drop, drop_count
  );

  modport slave (
    output fft_en,
    output in0_real, in1_real, in2_real, in3_real,
    output in4_real, in5_real, in6_real, in7_real,
    output in0_imag, in1_imag, in2_imag, in3_imag,
    output in4_imag, in5_imag, in6_imag, in7_imag,
    output out_ready,
    input  out_valid, out_real, out_imag, out_index, out_last,
    input  frame_drop, drop_count
  );

endinterface

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one frame of 8 complex words, parallel load, indexed read
// Ports: clk; load (capture all 16 words); in0..in7 real/imag; rd_index;
// rd_real/rd_imag combinational read of the selected bin.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic  clk,
  input  logic  load,
  input  word_t in0_real,
  input  word_t in1_real,
  input  word_t in2_real,
  input  word_t in3_real,
  input  word_t in4_real,
  input  word_t in5_real,
  input  word_t in6_real,
  input  word_t in7_real,
  input  word_t in0_imag,
  input  word_t in1_imag,
  input  word_t in2_imag,
  input  word_t in3_imag,
  input  word_t in4_imag,
  input  word_t in5_imag,
  input  word_t in6_imag,
  input  word_t in7_imag,
  input  bin_t  rd_index,
  output word_t rd_real,
  output word_t rd_imag
);

  word_t mem_real [NFFT];
  word_t mem_imag [NFFT];

  // Contents are qualified by the owner's full flag, so no reset is needed.
  always_ff @(posedge clk) begin
    if (load) begin
      mem_real[0] <= in0_real;
      mem_real[1] <= in1_real;
      mem_real[2] <= in2_real;
      mem_real[3] <= in3_real;
      mem_real[4] <= in4_real;
      mem_real[5] <= in5_real;
      mem_real[6] <= in6_real;
      mem_real[7] <= in7_real;
      mem_imag[0] <= in0_imag;
      mem_imag[1] <= in1_imag;
      mem_imag[2] <= in2_imag;
      mem_imag[3] <= in3_imag;
      mem_imag[4] <= in4_imag;
      mem_imag[5] <= in5_imag;
      mem_imag[6] <= in6_imag;
      mem_imag[7] <= in7_imag;
    end
  end

  assign rd_real = mem_real[rd_index];
  assign rd_imag = mem_imag[rd_index];

endmodule

// File: rtl/fft_out_serializer.sv
// rtl/fft_out_serializer.sv - ping-pong capture of FFT frames, one sample per cycle out
// Ports: clk; rst_n async active-low; bus (master modport) carrying fft_en,
// the parallel FFT frame, the valid/ready sample stream and drop reporting.
module fft_out_serializer #(
  parameter int LATENCY = fft_pkg::LATENCY
) (
  input logic                  clk,
  input logic                  rst_n,
  fft_out_serializer_if.master bus
);
  import fft_pkg::*;

  // Reset asserts immediately and releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  logic [LATENCY-1:0] en_dly;
  logic [1:0]         full;
  logic [1:0]         full_nxt;
  logic [1:0]         load;
  logic               wr_ptr;
  logic               rd_ptr;
  bin_t               idx;
  logic               cap_req;
  logic               cap_ok;
  logic               cap_drop;
  logic               valid;
  logic               accept;
  logic               frame_done;
  logic               frame_drop_q;
  drop_cnt_t          drop_count_q;
  word_t              bank_real [2];
  word_t              bank_imag [2];

  // Oldest fft_en sample in the delay line marks the cycle its frame appears.
  assign cap_req    = en_dly[LATENCY-1];
  assign valid      = full[rd_ptr];
  assign accept     = valid & bus.out_ready;
  assign frame_done = accept & (idx == bin_t'(NFFT - 1));

  // Release the read bank first so a capture on the same edge sees it empty.
  always_comb begin
    full_nxt = full;
    load     = 2'b00;
    if (frame_done) full_nxt[rd_ptr] = 1'b0;
    cap_ok   = cap_req & ~full_nxt[wr_ptr];
    cap_drop = cap_req &  full_nxt[wr_ptr];
    if (cap_ok) begin
      full_nxt[wr_ptr] = 1'b1;
      load[wr_ptr]     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      en_dly       <= '0;
      full         <= 2'b00;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      idx          <= '0;
      frame_drop_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      en_dly <= (en_dly << 1) | LATENCY'(bus.fft_en);
      full   <= full_nxt;
      if (cap_ok) wr_ptr <= ~wr_ptr;
      if (accept) begin
        if (frame_done) begin
          idx    <= '0;
          rd_ptr <= ~rd_ptr;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      frame_drop_q <= cap_drop;
      if (cap_drop && (drop_count_q != '1)) drop_count_q <= drop_count_q + 1'b1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_frame_bank u_bank (
      .clk      (clk),
      .load     (load[g]),
      .in0_real (bus.in0_real),
      .in1_real (bus.in1_real),
      .in2_real (bus.in2_real),
      .in3_real (bus.in3_real),
      .in4_real (bus.in4_real),
      .in5_real (bus.in5_real),
      .in6_real (bus.in6_real),
      .in7_real (bus.in7_real),
      .in0_imag (bus.in0_imag),
      .in1_imag (bus.in1_imag),
      .in2_imag (bus.in2_imag),
      .in3_imag (bus.in3_imag),
      .in4_imag (bus.in4_imag),
      .in5_imag (bus.in5_imag),
      .in6_imag (bus.in6_imag),
      .in7_imag (bus.in7_imag),
      .rd_index (idx),
      .rd_real  (bank_real[g]),
      .rd_imag  (bank_imag[g])
    );
  end

  // Data-side outputs are forced to zero whenever nothing is offered.
  assign bus.out_valid  = valid;
  assign bus.out_real   = valid ? bank_real[rd_ptr] : '0;
  assign bus.out_imag   = valid ? bank_imag[rd_ptr] : '0;
  assign bus.out_index  = valid ? idx : '0;
  assign bus.out_last   = valid & (idx == bin_t'(NFFT - 1));
  assign bus.frame_drop = frame_drop_q;
  assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb/tb_fft_out_serializer.sv - self-checking bench for fft_out_serializer
module tb_fft_out_serializer;
  import fft_pkg::*;

  typedef struct packed {
    logic [NFFT-1:0][DATA_WIDTH-1:0] re;
    logic [NFFT-1:0][DATA_WIDTH-1:0] im;
  } frame_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  int     n_cmp = 0;
  int     n_bad = 0;

  frame_t fq[$];
  bit     en_pipe[$];
  int     m_idx;
  bit     m_drop;
  int     m_cnt;
  frame_t cur;

  fft_out_serializer_if bus();

  fft_out_serializer #(.LATENCY(LATENCY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_frame();
    bus.in0_real = cur.re[0]; bus.in1_real = cur.re[1];
    bus.in2_real = cur.re[2]; bus.in3_real = cur.re[3];
    bus.in4_real = cur.re[4]; bus.in5_real = cur.re[5];
    bus.in6_real = cur.re[6]; bus.in7_real = cur.re[7];
    bus.in0_imag = cur.im[0]; bus.in1_imag = cur.im[1];
    bus.in2_imag = cur.im[2]; bus.in3_imag = cur.im[3];
    bus.in4_imag = cur.im[4]; bus.in5_imag = cur.im[5];
    bus.in6_imag = cur.im[6]; bus.in7_imag = cur.im[7];
  endtask

  task automatic model_reset();
    fq.delete();
    en_pipe.delete();
    for (int i = 0; i < LATENCY; i++) en_pipe.push_back(1'b0);
    m_idx  = 0;
    m_drop = 0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs();
    bit          v;
    logic [63:0] er, ei;
    v  = (fq.size() > 0);
    er = 64'd0;
    ei = 64'd0;
    if (v) begin
      er = 64'(fq[0].re[m_idx]);
      ei = 64'(fq[0].im[m_idx]);
    end
    check("out_valid",  64'(bus.out_valid),  64'(v));
    check("out_real",   64'(bus.out_real),   er);
    check("out_imag",   64'(bus.out_imag),   ei);
    check("out_index",  64'(bus.out_index),  v ? 64'(m_idx) : 64'd0);
    check("out_last",   64'(bus.out_last),   64'(v && m_idx == NFFT - 1));
    check("frame_drop", 64'(bus.frame_drop), 64'(m_drop));
    check("drop_count", 64'(bus.drop_count), 64'(m_cnt));
  endtask

  // One clock: check what the last edge produced, drive new inputs, then
  // advance the frame-queue model by what the coming edge will do.
  task automatic step(input bit en, input bit rdy, input bit rnd);
    bit cap;
    @(negedge clk);
    check_outputs();
    for (int k = 0; k < NFFT; k++) begin
      if (rnd) begin
        cur.re[k] = DATA_WIDTH'($urandom());
        cur.im[k] = DATA_WIDTH'($urandom());
      end else begin
        cur.re[k] = DATA_WIDTH'(k * 32'h0001_0000);
        cur.im[k] = DATA_WIDTH'(-k);
      end
    end
    drive_frame();
    bus.fft_en    = en;
    bus.out_ready = rdy;
    cap = en_pipe.pop_front();
    en_pipe.push_back(en);
    if (fq.size() > 0 && rdy) begin
      if (m_idx == NFFT - 1) begin
        void'(fq.pop_front());
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    m_drop = 0;
    if (cap) begin
      if (fq.size() < 2) fq.push_back(cur);
      else begin
        m_drop = 1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
    end
  endtask

  initial begin
    int lat;
    int run;
    int guard;
    int pe[4] = '{15, 60, 90, 30};
    int pr[4] = '{90, 50, 20, 70};

    cur = '0;
    drive_frame();
    bus.fft_en    = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_valid",  64'(bus.out_valid),  64'd0);
    check("rst_real",   64'(bus.out_real),   64'd0);
    check("rst_index",  64'(bus.out_index),  64'd0);
    check("rst_last",   64'(bus.out_last),   64'd0);
    check("rst_drop",   64'(bus.frame_drop), 64'd0);
    check("rst_count",  64'(bus.drop_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(0, 1, 0);

    // Single frame with bin-indexed pattern and first-sample latency
    step(1, 1, 0);
    lat = 0;
    do begin
      step(0, 1, 0);
      lat++;
    end while (!bus.out_valid && lat < 12);
    check("first_sample_latency", 64'(lat), 64'(LATENCY + 1));
    repeat (12) step(0, 1, 0);

    // Backpressure 1,0,0 pattern
    step(1, 1, 0);
    for (int i = 0; i < 36; i++) step(0, (i % 3) == 0, 0);

    // Overflow: three frames back to back with sink stalled
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
    repeat (6) step(0, 0, 1);
    check("ovf_drop_count", 64'(bus.drop_count), 64'd1);
    check("ovf_buffered",   64'(fq.size()),      64'd2);

    // Back-to-back drain of both banks
    step(0, 1, 1);
    run   = 0;
    guard = 0;
    while (bus.out_valid && guard < 24) begin
      run++;
      guard++;
      step(0, 1, 1);
    end
    check("b2b_valid_run", 64'(run), 64'(2 * NFFT));
    repeat (3) step(0, 1, 1);

    // Bin 7 leaving a bank on the same edge a new frame lands
    step(1, 0, 1); step(1, 0, 1);
    repeat (5) step(0, 0, 1);
    for (int i = 0; i < NFFT; i++) step(i == 3, 1, 1);
    step(0, 1, 1);
    check("same_edge_no_drop", 64'(bus.drop_count), 64'd1);
    repeat (20) step(0, 1, 1);

    // Reset mid-stream with another frame still in the FFT pipeline
    step(1, 0, 1);
    repeat (5) step(0, 0, 1);
    step(1, 1, 1);
    guard = 0;
    while (m_idx != 3 && guard < 10) begin
      step(0, 1, 1);
      guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid),  64'd0);
    check("mid_rst_real",  64'(bus.out_real),   64'd0);
    check("mid_rst_imag",  64'(bus.out_imag),   64'd0);
    check("mid_rst_index", 64'(bus.out_index),  64'd0);
    check("mid_rst_last",  64'(bus.out_last),   64'd0);
    check("mid_rst_count", 64'(bus.drop_count), 64'd0);
    model_reset();
    bus.fft_en = 1'b0;
    repeat (3) step(0, 1, 1);
    rst_n = 1'b1;
    repeat (12) step(0, 1, 1);

    // Randomized traffic with varying load and sink readiness
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 600; i++)
        step($urandom_range(99) < pe[s], $urandom_range(99) < pr[s], 1);
    end
    repeat (LATENCY + 1) step(0, 1, 1);
    repeat (20) step(0, 1, 1);
    check("final_empty", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
Unloader at the output end of the 8-point DIT FFT. It tracks fft_en through the FFT pipeline latency and captures each parallel output frame (8 complex samples, fixed-point INT.FRACT) into a two-bank ping-pong buffer. Frames are then streamed out one complex sample per cycle over a valid/ready interface. When both banks are occupied, arriving frames are dropped and counted.

Parameters:
INT_WIDTH, 16, integer field width of each real/imag word
FRACT_WIDTH, 16, fractional field width
DATA_WIDTH, INT_WIDTH+FRACT_WIDTH, word width (derived, not overridden)
NFFT, 8, points per frame (fixed at 8 for this block)
LATENCY, 4, FFT latency in clock cycles from fft_en sample to output capture

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fft_en  in  1  same signal that drives the FFT enable; a high sample marks one input frame
in0_real..in7_real  in  DATA_WIDTH each  FFT outputs out0_real..out7_real, natural order
in0_imag..in7_imag  in  DATA_WIDTH each  FFT outputs out0_imag..out7_imag
out_valid  out  1  stream sample valid
out_ready  in  1  downstream accepts sample when out_valid && out_ready
out_real  out  DATA_WIDTH  streamed real part
out_imag  out  DATA_WIDTH  streamed imag part
out_index  out  3  bin index 0..7 of current sample
out_last  out  1  high with index 7
frame_drop  out  1  one-cycle pulse when a frame is discarded
drop_count  out  16  saturating count of dropped frames

Behaviour:
- Reset (async assert, sync release): all outputs 0; both banks empty; write/read bank pointers 0; enable delay line cleared; sample index 0. Asserting reset mid-frame discards all buffered and in-flight frames.
- Latency tracking: fft_en sampled high at edge E means the frame is captured at edge E+LATENCY. A LATENCY-deep shift register of fft_en provides this; back-to-back fft_en produces a capture request every cycle.
- Capture: on a capture request, if the bank at wr_ptr is empty, load all 16 words, mark it full, and toggle wr_ptr. If both banks are full, drop the frame: pulse frame_drop for that cycle and increment drop_count, which saturates at 0xFFFF.
- Simultaneous events: a bank freed by acceptance of index 7 on the same edge counts as empty for a capture on that edge, so no drop occurs.
- Streaming: out_valid = bank[rd_ptr] full. out_real/out_imag come from bank[rd_ptr] at out_index.
  - On accept, out_index increments. On accepting index 7: clear the bank, toggle rd_ptr, reset index to 0.
  - With out_ready held high, frames stream back-to-back with no bubble across the bank switch.
- First-sample latency: with an idle buffer, out_valid rises in the cycle following edge E+LATENCY, i.e. LATENCY+1 edges after fft_en is sampled.
- Stability: while out_valid && !out_ready, out_real, out_imag, out_index and out_last hold. When out_valid is low, the data outputs, out_index and out_last drive 0.
- Ordering: frames are emitted in capture order. Samples are not reordered and no arithmetic is applied; words pass through bit-exact.
- Throughput: the sustained limit is one captured frame per 8 accepted samples. Extra frames drop as above.

Decomposition:
- Shared package fft_pkg: INT_WIDTH, FRACT_WIDTH, DATA_WIDTH, NFFT, LOG2_NFFT=3, LATENCY defaults, and the drop-counter width (16).
- Sub-module fft_frame_bank: one 8x complex register bank with load strobe, 16 parallel data inputs, 3-bit read index, and real/imag read outputs. Instantiated twice.
- Top level holds the delay line, pointers, full flags, index counter and drop logic.

Test Plan:
- Single frame: in*_real = k·0x0001_0000 (k = bin), imag = -k. One fft_en pulse, out_ready = 1 → out_valid rises LATENCY+1 edges later; 8 consecutive samples 0..7 with exact values; out_last only on index 7; out_valid then falls.
- Backpressure: same frame with out_ready toggling 1,0,0,1,... → no sample lost or duplicated; outputs stable during every stalled cycle.
- Overflow: fft_en high 3 consecutive cycles with distinct frames, out_ready = 0 → frames 1–2 buffered; frame 3 gives a frame_drop pulse and drop_count = 1. Raising out_ready later emits frame 1 then frame 2 (16 samples).
- Free-and-capture same edge: both banks full; index 7 of bank 0 accepted on the same edge a new capture arrives → no drop; the new frame streams after the other bank.
- Back-to-back drain: two buffered frames, out_ready = 1 → 16 consecutive valid cycles, no gap at index 7→0.
- Reset mid-stream: assert rst_n low at index 3 of a frame with a second frame in flight → all outputs 0 immediately; after release nothing is emitted until a new fft_en pulse.
